// File: rtl/spcore_if.sv
// Instruction/datapath bus of one spcore: operand indices, immediate, control
// strobes, and the memory-facing address/data lines.
interface spcore_if;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  z;
    logic [15:0] I;
    logic        P;
    logic [15:0] data_out;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        en;
    logic        reg_we;
    logic [3:0]  aluc;
    logic [1:0]  s2;

    modport master (
        output x, y, z, I, data_in, en, reg_we, aluc, s2,
        input  P, data_out, addr
    );

    modport slave (
        input  x, y, z, I, data_in, en, reg_we, aluc, s2,
        output P, data_out, addr
    );
endinterface

// File: rtl/spcore.sv
// Single-issue scalar core: 16x16 register file, registered ALU, write-back mux.
// Define SPCORE_MUL_EN to build the multiplier (MUL/MAD); otherwise MUL=0, MAD=R[x].
module spcore #(
    parameter int CORE_ID = 0,
    parameter int N_CORES = 1
) (
    input  logic     clk,
    input  logic     reset,
    spcore_if.slave  bus
);
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] CORE_ID_C = DATA_W'(CORE_ID);
    localparam logic [DATA_W-1:0] N_CORES_C = DATA_W'(N_CORES);

    typedef enum logic [3:0] {
        OP_CLEAR   = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_MUL     = 4'd3,
        OP_MAD     = 4'd4,
        OP_INC     = 4'd5,
        OP_CORE_ID = 4'd6,
        OP_N_CORES = 4'd7
    } op_e;

    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] rx, ry, rz;
    logic [DATA_W-1:0] mul_lo;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] alu_out_p1;
    logic [DATA_W-1:0] wdata;

    assign rx = regs[bus.x];
    assign ry = regs[bus.y];
    assign rz = regs[bus.z];

    assign bus.data_out = rx;
    assign bus.addr     = ry;
    assign bus.P        = (rx == '0);

`ifdef SPCORE_MUL_EN
    assign mul_lo = ry * rz;
`else
    assign mul_lo = '0;
`endif

    always_comb begin
        alu_res = '0;
        case (op_e'(bus.aluc))
            OP_CLEAR:   alu_res = '0;
            OP_ADD:     alu_res = ry + rz;
            OP_SUB:     alu_res = ry - rz;
            OP_MUL:     alu_res = mul_lo;
            OP_MAD:     alu_res = rx + mul_lo;
            OP_INC:     alu_res = rx + 16'd1;
            OP_CORE_ID: alu_res = CORE_ID_C;
            OP_N_CORES: alu_res = N_CORES_C;
            default:    alu_res = '0;
        endcase
    end

    always_comb begin
        wdata = alu_out_p1;
        case (bus.s2)
            2'd1:    wdata = bus.I;
            2'd2:    wdata = bus.data_in;
            default: wdata = alu_out_p1;
        endcase
    end

    // Stage p1: ALU result register and register-file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_p1 <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (bus.en) begin
            alu_out_p1 <= alu_res;
            if (bus.reg_we) regs[bus.x] <= wdata;
        end
    end
endmodule

// File: tb/tb_spcore.sv
// Directed, table-driven bench for spcore (CORE_ID=100, N_CORES=200).
module tb_spcore;
    logic clk = 1'b0;
    logic reset;
    spcore_if bus ();

    spcore #(.CORE_ID(100), .N_CORES(200)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef SPCORE_MUL_EN
    localparam logic [15:0] EXP_MAD = 16'd251;
    localparam logic [15:0] EXP_MUL = 16'd220;
`else
    localparam logic [15:0] EXP_MAD = 16'd31;
    localparam logic [15:0] EXP_MUL = 16'd0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst, en, we;
        logic [3:0]  aluc;
        logic [1:0]  s2;
        logic [3:0]  x, y, z;
        logic [15:0] imm, din;
        logic        chk;
        logic [3:0]  cx;
        logic [15:0] exp;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic en, input logic we,
                       input logic [3:0] aluc, input logic [1:0] s2,
                       input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                       input logic [15:0] imm, input logic [15:0] din,
                       input logic chk, input logic [3:0] cx, input logic [15:0] exp);
        vec_t v;
        v.rst = rst; v.en = en; v.we = we; v.aluc = aluc; v.s2 = s2;
        v.x = x; v.y = y; v.z = z; v.imm = imm; v.din = din;
        v.chk = chk; v.cx = cx; v.exp = exp;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic observe(input string name, input logic [3:0] cx, input logic [15:0] exp);
        bus.x = cx; bus.y = cx; bus.en = 1'b0; bus.reg_we = 1'b0;
        #1;
        check({name, ".data_out"}, bus.data_out, exp);
        check({name, ".addr"}, bus.addr, exp);
        check({name, ".P"}, {15'd0, bus.P}, {15'd0, (exp == 16'd0)});
    endtask

    initial begin
        bus.x = '0; bus.y = '0; bus.z = '0; bus.I = '0; bus.data_in = '0;
        bus.en = 1'b0; bus.reg_we = 1'b0; bus.aluc = '0; bus.s2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int r = 0; r < 16; r++) observe($sformatf("reset_r%0d", r), 4'(r), 16'd0);

        //   rst en we aluc  s2 x  y  z  imm       din       chk cx exp
        add(0, 1, 1, 4'd0, 1, 0, 0, 0, 16'd11,   16'd0,    1, 0, 16'd11);
        add(0, 1, 1, 4'd0, 1, 1, 0, 0, 16'd20,   16'd0,    1, 1, 16'd20);
        add(0, 1, 0, 4'd1, 0, 2, 0, 1, 16'd0,    16'd0,    1, 2, 16'd0);
        add(0, 1, 1, 4'd1, 0, 2, 0, 1, 16'd0,    16'd0,    1, 2, 16'd31);
        add(0, 1, 0, 4'd4, 0, 2, 0, 1, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd4, 0, 2, 0, 1, 16'd0,    16'd0,    1, 2, EXP_MAD);
        add(0, 1, 0, 4'd1, 0, 2, 0, 1, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd1, 0, 2, 0, 1, 16'd0,    16'd0,    1, 2, 16'd31);
        add(0, 1, 0, 4'd3, 0, 2, 0, 1, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd3, 0, 2, 0, 1, 16'd0,    16'd0,    1, 2, EXP_MUL);
        add(0, 1, 0, 4'd6, 0, 3, 0, 0, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd6, 3, 3, 0, 0, 16'd0,    16'd0,    1, 3, 16'd100);
        add(0, 1, 0, 4'd7, 0, 3, 0, 0, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd7, 0, 3, 0, 0, 16'd0,    16'd0,    1, 3, 16'd200);
        add(0, 1, 0, 4'd0, 0, 3, 0, 0, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd0, 0, 3, 0, 0, 16'd0,    16'd0,    1, 3, 16'd0);
        add(0, 1, 0, 4'd5, 0, 3, 0, 0, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd5, 0, 3, 0, 0, 16'd0,    16'd0,    1, 3, 16'd1);
        add(0, 1, 0, 4'd9, 0, 3, 0, 0, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd9, 0, 8, 0, 0, 16'd0,    16'd0,    1, 8, 16'd0);
        add(0, 1, 1, 4'd0, 1, 0, 0, 0, 16'hFFFF, 16'd0,    1, 0, 16'hFFFF);
        add(0, 1, 0, 4'd5, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd5, 0, 0, 0, 0, 16'd0,    16'd0,    1, 0, 16'd0);
        add(0, 1, 0, 4'd2, 0, 5, 0, 3, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd2, 0, 5, 0, 3, 16'd0,    16'd0,    1, 5, 16'hFFFF);
        add(0, 0, 1, 4'd0, 1, 5, 0, 0, 16'd5,    16'd0,    1, 5, 16'hFFFF);
        add(0, 1, 0, 4'd1, 0, 6, 3, 3, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 0, 0, 4'd0, 0, 6, 3, 3, 16'd0,    16'd0,    0, 0, 16'd0);
        add(0, 1, 1, 4'd0, 0, 6, 3, 3, 16'd0,    16'd0,    1, 6, 16'd2);
        add(1, 1, 1, 4'd0, 1, 3, 0, 0, 16'd7,    16'd0,    1, 3, 16'd0);
        add(0, 0, 0, 4'd0, 0, 0, 0, 0, 16'd0,    16'd0,    1, 5, 16'd0);
        add(0, 0, 0, 4'd0, 0, 0, 0, 0, 16'd0,    16'd0,    1, 6, 16'd0);
        add(0, 1, 1, 4'd0, 2, 4, 0, 0, 16'd0,    16'h1234, 1, 4, 16'h1234);
        add(0, 1, 0, 4'd1, 0, 4, 4, 4, 16'd0,    16'd0,    0, 0, 16'd0);
        add(1, 1, 0, 4'd1, 0, 4, 4, 4, 16'd0,    16'd0,    1, 4, 16'd0);
        add(0, 1, 1, 4'd1, 0, 9, 4, 4, 16'd0,    16'd0,    1, 9, 16'd0);

        foreach (tv[i]) begin
            @(negedge clk);
            reset       = tv[i].rst;
            bus.en      = tv[i].en;
            bus.reg_we  = tv[i].we;
            bus.aluc    = tv[i].aluc;
            bus.s2      = tv[i].s2;
            bus.x       = tv[i].x;
            bus.y       = tv[i].y;
            bus.z       = tv[i].z;
            bus.I       = tv[i].imm;
            bus.data_in = tv[i].din;
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (tv[i].chk) observe($sformatf("v%0d", i), tv[i].cx, tv[i].exp);
        end

        // Read-during-write: old value visible until the edge, new value after
        @(negedge clk);
        bus.en = 1'b1; bus.reg_we = 1'b1; bus.s2 = 2'd1; bus.x = 4'd7; bus.y = 4'd7;
        bus.I = 16'h0055;
        #1;
        check("rdw_before", bus.data_out, 16'h0000);
        check("rdw_P_before", {15'd0, bus.P}, 16'd1);
        @(posedge clk);
        #1;
        check("rdw_after", bus.data_out, 16'h0055);
        check("rdw_addr_after", bus.addr, 16'h0055);

        // Reset overrides en/reg_we on the same edge
        @(negedge clk);
        reset = 1'b1; bus.I = 16'h00AA;
        @(posedge clk);
        #1;
        reset = 1'b0; bus.reg_we = 1'b0; bus.en = 1'b0;
        check("rst_override", bus.data_out, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
